// File: rtl/tracking_pkg.sv
// Shared constants and state encoding for the object-tracking pipeline
// (centroid front end feeding the Kalman measurement ports).
package tracking_pkg;

    localparam int unsigned TRK_DISP_WIDTH = 11;
    localparam int unsigned TRK_CNT_W      = 21;
    localparam int unsigned TRK_SUM_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVIDE  = 2'd1,
        ST_PRESENT = 2'd2
    } centroid_state_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, W iterations,
// done pulses for one cycle after the last iteration.
module seq_divider #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dsr_q, dsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W:0]    shifted_c;
    logic [W-1:0]  diff_c;

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        shifted_c = {rem_q, quo_q[W-1]};
        // True difference is below the divisor whenever it is taken, so W bits suffice.
        diff_c = shifted_c[W-1:0] - dsr_q;
        if (start && !busy_q) begin
            quo_d  = dividend;
            dsr_d  = divisor;
            rem_d  = '0;
            cnt_d  = CW'(W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (shifted_c >= {1'b0, dsr_q}) begin
                rem_d = diff_c;
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = shifted_c[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/centroid_calc.sv
// Accumulates hit-pixel coordinates per frame and presents the centroid
// as a (z_x, z_y) measurement on a valid/ready handshake.
module centroid_calc
    import tracking_pkg::*;
#(
    parameter int unsigned DISP_WIDTH = TRK_DISP_WIDTH,
    parameter int unsigned CNT_W      = TRK_CNT_W,
    parameter int unsigned SUM_W      = TRK_SUM_W,
    parameter int unsigned MIN_PIXELS = 16
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  pix_valid,
    input  logic [DISP_WIDTH-1:0] pix_x,
    input  logic [DISP_WIDTH-1:0] pix_y,
    input  logic                  pix_hit,
    input  logic                  frame_end,
    output logic [DISP_WIDTH-1:0] z_x,
    output logic [DISP_WIDTH-1:0] z_y,
    output logic                  valid,
    input  logic                  ready,
    output logic                  lost,
    output logic                  overrun
);

    centroid_state_e       state_q, state_d;
    logic [SUM_W-1:0]      sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DISP_WIDTH-1:0] z_x_q, z_x_d, z_y_q, z_y_d;
    logic                  valid_q, valid_d;
    logic                  lost_q, lost_d;
    logic                  overrun_q, overrun_d;

    logic                  hit_c;
    logic [SUM_W-1:0]      snap_x_c, snap_y_c;
    logic [CNT_W-1:0]      snap_cnt_c;
    logic                  start_c;
    logic                  div_busy_x, div_busy_y, div_done_x, div_done_y;
    logic [SUM_W-1:0]      quo_x, quo_y;
    logic                  div_unused_c;

    // Running totals including this cycle's pixel; this is also the frame-end snapshot.
    always_comb begin
        hit_c      = pix_valid && pix_hit;
        snap_x_c   = sum_x_q + (hit_c ? SUM_W'(pix_x) : '0);
        snap_y_c   = sum_y_q + (hit_c ? SUM_W'(pix_y) : '0);
        snap_cnt_c = (hit_c && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        start_c    = frame_end && (state_q == ST_IDLE)
                     && (snap_cnt_c >= CNT_W'(MIN_PIXELS));
    end

    seq_divider #(.W(SUM_W)) u_div_x (
        .clk      (clk),
        .aresetn  (aresetn),
        .start    (start_c),
        .dividend (snap_x_c),
        .divisor  (SUM_W'(snap_cnt_c)),
        .busy     (div_busy_x),
        .done     (div_done_x),
        .quotient (quo_x)
    );

    seq_divider #(.W(SUM_W)) u_div_y (
        .clk      (clk),
        .aresetn  (aresetn),
        .start    (start_c),
        .dividend (snap_y_c),
        .divisor  (SUM_W'(snap_cnt_c)),
        .busy     (div_busy_y),
        .done     (div_done_y),
        .quotient (quo_y)
    );

    // Quotient never exceeds the largest coordinate, so only the low bits matter.
    assign div_unused_c = ^{div_busy_x, div_busy_y,
                            quo_x[SUM_W-1:DISP_WIDTH], quo_y[SUM_W-1:DISP_WIDTH]};

    always_comb begin
        state_d   = state_q;
        z_x_d     = z_x_q;
        z_y_d     = z_y_q;
        valid_d   = valid_q;
        lost_d    = 1'b0;
        overrun_d = 1'b0;
        sum_x_d   = frame_end ? '0 : snap_x_c;
        sum_y_d   = frame_end ? '0 : snap_y_c;
        cnt_d     = frame_end ? '0 : snap_cnt_c;
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d = ST_DIVIDE;
                end else if (frame_end) begin
                    lost_d = 1'b1;
                end
            end
            ST_DIVIDE: begin
                overrun_d = frame_end;
                if (div_done_x && div_done_y) begin
                    z_x_d   = quo_x[DISP_WIDTH-1:0];
                    z_y_d   = quo_y[DISP_WIDTH-1:0];
                    valid_d = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                overrun_d = frame_end;
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            sum_x_q   <= '0;
            sum_y_q   <= '0;
            cnt_q     <= '0;
            z_x_q     <= '0;
            z_y_q     <= '0;
            valid_q   <= 1'b0;
            lost_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sum_x_q   <= sum_x_d;
            sum_y_q   <= sum_y_d;
            cnt_q     <= cnt_d;
            z_x_q     <= z_x_d;
            z_y_q     <= z_y_d;
            valid_q   <= valid_d;
            lost_q    <= lost_d;
            overrun_q <= overrun_d;
        end
    end

    assign z_x     = z_x_q;
    assign z_y     = z_y_q;
    assign valid   = valid_q;
    assign lost    = lost_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_centroid_calc.sv
// Self-checking bench for centroid_calc: vector table, directed multi-cycle
// sequences and random frames against an arithmetic centroid model.
module tb_centroid_calc;

    localparam int EXP_LAT = 33;   // edges from the frame_end edge to valid
    localparam int MIN_PIX = 16;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        pix_valid, pix_hit, frame_end, ready;
    logic [10:0] pix_x, pix_y;
    logic [10:0] z_x, z_y;
    logic        valid, lost, overrun;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic v;
        logic h;
        int   x;
        int   y;
    } pix_t;

    typedef struct {
        int x0; int w; int y0; int h; int rep;
        bit ext; int ex; int ey;
        bit exp_lost; int exp_zx; int exp_zy;
    } vec_t;

    pix_t fr_q[$];
    vec_t vecs[8];

    centroid_calc dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_hit   (pix_hit),
        .frame_end (frame_end),
        .z_x       (z_x),
        .z_y       (z_y),
        .valid     (valid),
        .ready     (ready),
        .lost      (lost),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_block(input int x0, input int w, input int y0, input int h, input int rep);
        for (int yy = y0; yy < y0 + h; yy++)
            for (int xx = x0; xx < x0 + w; xx++)
                for (int r = 0; r < rep; r++)
                    fr_q.push_back('{1'b1, 1'b1, xx, yy});
    endtask

    // Drives fr_q one entry per cycle, frame_end on the last; returns just after that edge.
    task automatic run_frame();
        for (int i = 0; i < fr_q.size(); i++) begin
            pix_valid = fr_q[i].v;
            pix_hit   = fr_q[i].h;
            pix_x     = 11'(fr_q[i].x);
            pix_y     = 11'(fr_q[i].y);
            frame_end = (i == fr_q.size() - 1);
            step();
        end
        pix_valid = 1'b0;
        pix_hit   = 1'b0;
        frame_end = 1'b0;
        fr_q.delete();
    endtask

    // Reference: centroid is the truncated mean of qualified hit coordinates.
    task automatic model(output int cnt, output int zx, output int zy);
        longint sx = 0, sy = 0;
        cnt = 0;
        foreach (fr_q[i]) if (fr_q[i].v && fr_q[i].h) begin
            sx += fr_q[i].x;
            sy += fr_q[i].y;
            cnt++;
        end
        zx = (cnt > 0) ? int'(sx / cnt) : 0;
        zy = (cnt > 0) ? int'(sy / cnt) : 0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic no_valid(input string nm, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (valid) seen++;
        end
        chk(nm, seen, 0);
    endtask

    initial begin
        int lat, cnt, ezx, ezy, bad, k;

        vecs[0] = '{100, 1, 50, 1, 1, 1'b0, 0, 0, 1'b1, 0, 0};
        vecs[1] = '{20, 10, 40, 10, 1, 1'b0, 0, 0, 1'b0, 24, 44};
        vecs[2] = '{500, 10, 200, 10, 1, 1'b0, 0, 0, 1'b0, 504, 204};
        vecs[3] = '{0, 1, 0, 1, 16, 1'b1, 1700, 1700, 1'b0, 100, 100};
        vecs[4] = '{10, 1, 10, 1, 15, 1'b0, 0, 0, 1'b1, 0, 0};
        vecs[5] = '{7, 1, 9, 1, 16, 1'b0, 0, 0, 1'b0, 7, 9};
        vecs[6] = '{2046, 2, 2046, 2, 4, 1'b0, 0, 0, 1'b0, 2046, 2046};
        vecs[7] = '{0, 3, 1000, 1, 6, 1'b0, 0, 0, 1'b0, 1, 1000};

        aresetn = 1'b0; pix_valid = 1'b0; pix_hit = 1'b0; frame_end = 1'b0;
        ready = 1'b0; pix_x = '0; pix_y = '0;
        repeat (3) step();
        chk("reset valid", int'(valid), 0);
        chk("reset lost", int'(lost), 0);
        chk("reset overrun", int'(overrun), 0);
        chk("reset z_x", int'(z_x), 0);
        chk("reset z_y", int'(z_y), 0);
        aresetn = 1'b1;
        step();

        // Vector table, ready held high
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            add_block(vecs[i].x0, vecs[i].w, vecs[i].y0, vecs[i].h, vecs[i].rep);
            if (vecs[i].ext) fr_q.push_back('{1'b1, 1'b1, vecs[i].ex, vecs[i].ey});
            run_frame();
            chk($sformatf("vec%0d lost", i), int'(lost), int'(vecs[i].exp_lost));
            chk($sformatf("vec%0d overrun", i), int'(overrun), 0);
            if (vecs[i].exp_lost) begin
                no_valid($sformatf("vec%0d no valid", i), 40);
            end else begin
                wait_valid(lat);
                chk($sformatf("vec%0d latency", i), lat, EXP_LAT);
                chk($sformatf("vec%0d z_x", i), int'(z_x), vecs[i].exp_zx);
                chk($sformatf("vec%0d z_y", i), int'(z_y), vecs[i].exp_zy);
                step();
                chk($sformatf("vec%0d valid drop", i), int'(valid), 0);
                chk($sformatf("vec%0d z_x hold", i), int'(z_x), vecs[i].exp_zx);
            end
        end

        // Backpressure: result held 200 cycles
        ready = 1'b0;
        add_block(20, 10, 40, 10, 1);
        run_frame();
        wait_valid(lat);
        chk("bp latency", lat, EXP_LAT);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!valid || z_x != 11'd24 || z_y != 11'd44) bad++;
        end
        chk("bp held cycles bad", bad, 0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("bp valid drop", int'(valid), 0);
        chk("bp z_x after", int'(z_x), 24);

        // Overrun while presenting, then clean third frame
        add_block(20, 10, 40, 10, 1);
        run_frame();
        wait_valid(lat);
        chk("ovr first latency", lat, EXP_LAT);
        add_block(300, 10, 0, 10, 1);
        run_frame();
        chk("ovr pulse", int'(overrun), 0 + 1);
        chk("ovr no lost", int'(lost), 0);
        chk("ovr valid kept", int'(valid), 1);
        chk("ovr z_x intact", int'(z_x), 24);
        chk("ovr z_y intact", int'(z_y), 44);
        step();
        chk("ovr one-cycle", int'(overrun), 0);
        ready = 1'b1;
        step();
        chk("ovr drained", int'(valid), 0);
        add_block(500, 10, 200, 10, 1);
        run_frame();
        wait_valid(lat);
        chk("third latency", lat, EXP_LAT);
        chk("third z_x", int'(z_x), 504);
        chk("third z_y", int'(z_y), 204);
        step();

        // Overrun while dividing
        add_block(20, 10, 40, 10, 1);
        run_frame();
        add_block(5, 1, 5, 1, 16);
        run_frame();
        chk("ovr div pulse", int'(overrun), 1);
        wait_valid(lat);
        chk("ovr div z_x", int'(z_x), 24);
        chk("ovr div z_y", int'(z_y), 44);
        step();
        no_valid("ovr div no extra", 40);

        // Reset mid-divide
        add_block(500, 10, 200, 10, 1);
        run_frame();
        repeat (10) step();
        aresetn = 1'b0;
        step();
        chk("rst valid", int'(valid), 0);
        chk("rst z_x", int'(z_x), 0);
        chk("rst z_y", int'(z_y), 0);
        aresetn = 1'b1;
        no_valid("rst no spurious", 45);
        add_block(20, 10, 40, 10, 1);
        run_frame();
        wait_valid(lat);
        chk("rst after latency", lat, EXP_LAT);
        chk("rst after z_x", int'(z_x), 24);
        chk("rst after z_y", int'(z_y), 44);
        step();

        // Random frames against the model, random ready stalls
        for (int f = 0; f < 30; f++) begin
            int n = $urandom_range(1, 48);
            int hit_pct = $urandom_range(20, 100);
            for (int i = 0; i < n; i++)
                fr_q.push_back('{logic'($urandom_range(0, 99) < 85),
                                 logic'($urandom_range(0, 99) < hit_pct),
                                 int'($urandom_range(0, 2047)),
                                 int'($urandom_range(0, 2047))});
            model(cnt, ezx, ezy);
            ready = 1'b0;
            run_frame();
            chk($sformatf("rnd%0d lost", f), int'(lost), int'(cnt < MIN_PIX));
            if (cnt < MIN_PIX) begin
                no_valid($sformatf("rnd%0d no valid", f), 36);
            end else begin
                wait_valid(lat);
                chk($sformatf("rnd%0d latency", f), lat, EXP_LAT);
                chk($sformatf("rnd%0d z_x", f), int'(z_x), ezx);
                chk($sformatf("rnd%0d z_y", f), int'(z_y), ezy);
                k = $urandom_range(0, 4);
                bad = 0;
                for (int i = 0; i < k; i++) begin
                    step();
                    if (!valid || int'(z_x) != ezx || int'(z_y) != ezy) bad++;
                end
                chk($sformatf("rnd%0d stall", f), bad, 0);
                ready = 1'b1;
                step();
                chk($sformatf("rnd%0d drop", f), int'(valid), 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
